// File: rtl/prefix_adder_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prefix_adder_sequencer
// Description : Iterative Kogge-Stone adder; one shared prefix stage is reused
//               over STAGES cycles. Optional macro PREFIX_ADDER_OVF_EN adds a
//               registered signed-overflow output (ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module prefix_adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef PREFIX_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = $clog2(WIDTH);
    localparam int KW     = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_p0;
    logic             r_cin;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [WIDTH-1:0] w_p0_in;
    logic [WIDTH-1:0] w_dist;
    logic [WIDTH-1:0] w_g_next;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_carry;
    logic             w_last;
    logic             w_accept;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_k == KW'(STAGES - 1));
    assign w_p0_in   = a ^ b;

    // Bits below the distance see zero from the shifted operand and a one in
    // the mask, so they behave as pass-through cells; the rest are combine cells.
    always_comb begin
        w_dist   = WIDTH'(1) << r_k;
        w_g_next = r_g | (r_p & (r_g << w_dist));
        w_p_next = r_p & ((r_p << w_dist) | (w_dist - WIDTH'(1)));
        w_carry  = {w_g_next[WIDTH-2:0], r_cin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = PREFIX;
            PREFIX:  if (w_last)   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_g    <= '0;
            r_p    <= '0;
            r_p0   <= '0;
            r_cin  <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            // Carry-in is folded into bit 0 so the prefix tree needs no extra column.
            r_k   <= '0;
            r_p0  <= w_p0_in;
            r_p   <= {w_p0_in[WIDTH-1:1], 1'b0};
            r_g   <= (a & b) | {{(WIDTH-1){1'b0}}, w_p0_in[0] & cin};
            r_cin <= cin;
        end else if (r_state == PREFIX) begin
            r_g <= w_g_next;
            r_p <= w_p_next;
            r_k <= r_k + KW'(1);
            if (w_last) begin
                r_sum  <= r_p0 ^ w_carry;
                r_cout <= w_g_next[WIDTH-1];
            end
        end
    end

`ifdef PREFIX_ADDER_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == PREFIX) && w_last) begin
            r_ovf <= w_carry[WIDTH-1] ^ w_g_next[WIDTH-1];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized and directed self-checking bench for prefix_adder_sequencer,
// compared every cycle against a transaction-level timing/arithmetic model.
module tb_prefix_adder_sequencer;

    localparam int WIDTH  = 16;
    localparam int STAGES = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef PREFIX_ADDER_OVF_EN
    logic             ovf;
`endif

    prefix_adder_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef PREFIX_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one operation in flight; result valid from the
    // STAGES-th edge after the accept edge until a handshake edge.
    bit               m_busy = 0;
    int               n_edge = 0;
    int               m_acc  = 0;
    int               n_acc  = 0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [WIDTH:0] t;
        if (!rst_n) begin
            m_busy = 0;
        end else begin
            n_edge++;
            if (!m_busy) begin
                if (in_valid) begin
                    t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                    m_sum  = t[WIDTH-1:0];
                    m_cout = t[WIDTH];
                    m_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
                    m_acc  = n_edge;
                    m_busy = 1;
                    n_acc++;
                end
            end else if (n_edge >= m_acc + STAGES + 1 && out_ready) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_v;
        exp_v = m_busy && (n_edge >= m_acc + STAGES);
        chk("out_valid", out_valid, exp_v);
        chk("in_ready", in_ready, !m_busy);
        chk("busy", busy, m_busy);
        if (exp_v) begin
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
`ifdef PREFIX_ADDER_OVF_EN
            chk("ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
        bit ok = 0;
        in_valid = 1'b1; a = ta; b = tb_; cin = tc;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            bad++; total++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts the
    // accept edge itself as edge 1.
    task automatic wait_result(output int lat);
        bit got = 0;
        lat = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!got) begin
            bad++; total++;
            $display("FAIL result_timeout: got no out_valid expected out_valid within 60 cycles");
        end
    endtask

    task automatic handshake_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // Wrap-around with latency measurement
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_result(lat);
        chk("wrap_latency", lat, 5);
        chk("wrap_sum", sum, 16'h0000);
        chk("wrap_cout", cout, 1'b1);
`ifdef PREFIX_ADDER_OVF_EN
        chk("wrap_ovf", ovf, 1'b0);
`endif
        handshake_edge();

        // Carry-in pushing into the sign bit
        send(16'h7FFF, 16'h0000, 1'b1);
        wait_result(lat);
        chk("cin_sum", sum, 16'h8000);
        chk("cin_cout", cout, 1'b0);
`ifdef PREFIX_ADDER_OVF_EN
        chk("cin_ovf", ovf, 1'b1);
`endif
        handshake_edge();

        // Backpressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_sum", sum, 16'h5555);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        handshake_edge();
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_out_valid", out_valid, 1'b0);

        // Operands offered while busy must be ignored
        send(16'h00FF, 16'h0001, 1'b0);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        wait_result(lat);
        chk("busy_first_sum", sum, 16'h0100);
        chk("busy_first_cout", cout, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b0);
        wait_result(lat);
        chk("busy_second_sum", sum, 16'hFFFF);
        chk("busy_second_cout", cout, 1'b0);
        handshake_edge();

        // Asynchronous reset in the middle of PREFIX
        send(16'h8000, 16'h8000, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 16'h0000);
        chk("midrst_cout", cout, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("postrst_out_valid", out_valid, 1'b0);
            chk("postrst_in_ready", in_ready, 1'b1);
        end

        // Random sweep with input gaps and output stalls
        acc0 = n_acc;
        for (int c = 0; c < 40000 && (n_acc - acc0) < 1000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            cin       = 1'($urandom % 2);
            out_ready = ($urandom % 3) != 0;
        end
        chk("random_ops_done", ((n_acc - acc0) >= 1000), 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
